// File: rtl/fpmult_prep_pipe.sv
// fpmult_prep_pipe: operand unpack/classify stage for the FP multiplier with a 2-entry skid buffer
// Optional build macro: FPPREP_SUBNORM_EN keeps subnormals (hidden bit 0, e=1); otherwise they flush to zero.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand-side handshake; a, b packed {sign, exp, man}
//   out_valid/out_ready   result-side handshake
//   sa, sb, sp            operand signs and product sign
//   ea, eb, ma, mb        effective exponents, mantissas with hidden bit in MSB
//   esum                  signed ea+eb-bias
//   exc                   {any, zero, a_nan, b_nan, a_inf, b_inf}
//   cnt_clr, exc_cnt      clear and value of the saturating exception counter
module fpmult_prep_pipe #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sa,
    output logic               sb,
    output logic               sp,
    output logic [EXP_W-1:0]   ea,
    output logic [EXP_W-1:0]   eb,
    output logic [MAN_W:0]     ma,
    output logic [MAN_W:0]     mb,
    output logic [EXP_W+1:0]   esum,
    output logic [5:0]         exc,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   exc_cnt
);
    localparam int FW = EXP_W + MAN_W + 4;
    localparam int PW = 3 + 2*EXP_W + 2*(MAN_W+1) + EXP_W + 2 + 6;
    localparam logic [EXP_W+1:0] BIAS = (EXP_W+2)'((1 << (EXP_W-1)) - 1);

    // Returns {zero, nan, inf, effective exponent, mantissa with hidden bit}.
    function automatic logic [FW-1:0] prep(input logic [EXP_W+MAN_W-1:0] f);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        logic ez, e1, mz;
        e  = f[MAN_W +: EXP_W];
        m  = f[MAN_W-1:0];
        ez = ~|e;
        e1 = &e;
        mz = ~|m;
`ifdef FPPREP_SUBNORM_EN
        return {ez & mz, e1 & ~mz, e1 & mz, (ez & ~mz) ? EXP_W'(1) : e, ~ez, m};
`else
        return {ez, e1 & ~mz, e1 & mz, e, ~ez, ez ? MAN_W'(0) : m};
`endif
    endfunction

    logic [FW-1:0]    pa, pb;
    logic [EXP_W-1:0] ea_n, eb_n;
    logic [EXP_W+1:0] esum_n;
    logic [5:0]       exc_n;
    logic [PW-1:0]    din, od, sd;
    logic             ov, sv, acc, drain;
    logic [CNT_W-1:0] cnt;

    assign pa     = prep(a[EXP_W+MAN_W-1:0]);
    assign pb     = prep(b[EXP_W+MAN_W-1:0]);
    assign ea_n   = pa[MAN_W+1 +: EXP_W];
    assign eb_n   = pb[MAN_W+1 +: EXP_W];
    assign esum_n = {2'b00, ea_n} + {2'b00, eb_n} - BIAS;
    assign exc_n  = {pa[FW-1] | pb[FW-1] | pa[FW-2] | pb[FW-2] | pa[FW-3] | pb[FW-3],
                     pa[FW-1] | pb[FW-1], pa[FW-2], pb[FW-2], pa[FW-3], pb[FW-3]};
    assign din    = {a[EXP_W+MAN_W], b[EXP_W+MAN_W], a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W],
                     ea_n, eb_n, pa[MAN_W:0], pb[MAN_W:0], esum_n, exc_n};

    assign in_ready  = ~sv;
    assign out_valid = ov;
    assign exc_cnt   = cnt;
    assign acc       = in_valid & ~sv;
    assign drain     = ov & out_ready;
    assign {sa, sb, sp, ea, eb, ma, mb, esum, exc} = od;

    // The skid entry is only ever filled while the output register is full,
    // so sv implies ov and an accept never coincides with a full skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov  <= 1'b0;
            sv  <= 1'b0;
            od  <= '0;
            sd  <= '0;
            cnt <= '0;
        end else begin
            if (sv) begin
                if (drain) begin
                    od <= sd;
                    sv <= 1'b0;
                end
            end else if (!ov || drain) begin
                ov <= acc;
                if (acc) od <= din;
            end else if (acc) begin
                sv <= 1'b1;
                sd <= din;
            end
            if (cnt_clr) cnt <= '0;
            else if (drain && od[5] && !(&cnt)) cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fpmult_prep_pipe.sv
// tb_fpmult_prep_pipe: directed self-checking bench for fpmult_prep_pipe (EXP_W=3, MAN_W=4, CNT_W=2)
module tb_fpmult_prep_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       sa, sb, sp;
    logic [2:0] ea, eb;
    logic [4:0] ma, mb;
    logic [4:0] esum;
    logic [5:0] exc;
    logic       cnt_clr = 1'b0;
    logic [1:0] exc_cnt;
    int tests = 0;
    int fails = 0;

    fpmult_prep_pipe #(.EXP_W(3), .MAN_W(4), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .sa(sa), .sb(sb), .sp(sp), .ea(ea), .eb(eb), .ma(ma), .mb(mb),
        .esum(esum), .exc(exc), .cnt_clr(cnt_clr), .exc_cnt(exc_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    initial begin
        go(); go();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_exc_cnt", 32'(exc_cnt), 0);
        chk("rst_payload", {esum, ma, mb, exc}, 0);
        rst_n = 1'b1;
        go();
        // normal pair
        a = 8'h35; b = 8'h42; in_valid = 1'b1;
        go();
        in_valid = 1'b0;
        chk("n_valid", 32'(out_valid), 1);
        chk("n_ea", 32'(ea), 3);
        chk("n_eb", 32'(eb), 4);
        chk("n_ma", 32'(ma), 32'h15);
        chk("n_mb", 32'(mb), 32'h12);
        chk("n_esum", 32'(esum), 4);
        chk("n_sp", 32'(sp), 0);
        chk("n_exc", 32'(exc), 0);
        // zero and sign; new pair loads while the previous one drains
        a = 8'h80; b = 8'h35; in_valid = 1'b1;
        go();
        in_valid = 1'b0;
        chk("z_valid", 32'(out_valid), 1);
        chk("z_sp", 32'(sp), 1);
        chk("z_exc", 32'(exc), 32'h30);
        chk("z_cnt_pre", 32'(exc_cnt), 0);
        go();
        chk("z_cnt_post", 32'(exc_cnt), 1);
        chk("z_drained", 32'(out_valid), 0);
        // specials back-to-back
        a = 8'h71; b = 8'h42; in_valid = 1'b1;
        go();
        chk("nan_exc", 32'(exc), 32'h28);
        a = 8'h70; b = 8'hF0;
        go();
        chk("inf_exc", 32'(exc), 32'h23);
        chk("inf_sp", 32'(sp), 1);
        chk("inf_esum", 32'(esum), 32'h0B);
        chk("inf_cnt", 32'(exc_cnt), 2);
        a = 8'h80; b = 8'h35;
        go();
        chk("sat_cnt3", 32'(exc_cnt), 3);
        go();
        in_valid = 1'b0;
        go();
        chk("sat_cnt5", 32'(exc_cnt), 3);
        chk("sat_valid", 32'(out_valid), 0);
        // subnormal operand
        a = 8'h05; b = 8'h40; in_valid = 1'b1;
        go();
        in_valid = 1'b0;
        chk("sub_eb", 32'(eb), 4);
        chk("sub_mb", 32'(mb), 32'h10);
`ifdef FPPREP_SUBNORM_EN
        chk("sub_ea", 32'(ea), 1);
        chk("sub_ma", 32'(ma), 32'h05);
        chk("sub_exc", 32'(exc), 0);
        chk("sub_esum", 32'(esum), 2);
`else
        chk("sub_ea", 32'(ea), 0);
        chk("sub_ma", 32'(ma), 0);
        chk("sub_exc", 32'(exc), 32'h30);
        chk("sub_esum", 32'(esum), 1);
`endif
        go();
        // clear coincident with an exception delivery
        a = 8'h80; b = 8'h35; in_valid = 1'b1;
        go();
        in_valid = 1'b0;
        cnt_clr = 1'b1;
        go();
        cnt_clr = 1'b0;
        chk("clr_cnt", 32'(exc_cnt), 0);
        // backpressure: two accepted, third held off
        out_ready = 1'b0;
        a = 8'h35; b = 8'h42; in_valid = 1'b1;
        go();
        chk("bp_rdy1", 32'(in_ready), 1);
        chk("bp_valid1", 32'(out_valid), 1);
        a = 8'h40; b = 8'h35;
        go();
        chk("bp_rdy2", 32'(in_ready), 0);
        a = 8'h25; b = 8'h40;
        go();
        chk("bp_rdy3", 32'(in_ready), 0);
        chk("bp_hold_ma", 32'(ma), 32'h15);
        chk("bp_hold_ea", 32'(ea), 3);
        out_ready = 1'b1;
        go();
        chk("bp_ea2", 32'(ea), 4);
        chk("bp_ma2", 32'(ma), 32'h10);
        chk("bp_rdy4", 32'(in_ready), 1);
        go();
        in_valid = 1'b0;
        chk("bp_ea3", 32'(ea), 2);
        chk("bp_ma3", 32'(ma), 32'h15);
        chk("bp_valid3", 32'(out_valid), 1);
        go();
        chk("bp_empty", 32'(out_valid), 0);
        // reset mid-stream
        a = 8'h80; b = 8'h35; in_valid = 1'b1;
        go();
        go();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("mr_cnt", 32'(exc_cnt), 1);
        chk("mr_valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_valid0", 32'(out_valid), 0);
        chk("mr_cnt0", 32'(exc_cnt), 0);
        chk("mr_rdy", 32'(in_ready), 1);
        go();
        rst_n = 1'b1;
        out_ready = 1'b1;
        go();
        chk("mr_no_spurious", 32'(out_valid), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
